// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop synchronised line, mid-bit 2-of-3 majority voting, optional parity, 1 or 2 stop bits.
// Latency: valid rises the cycle after the final stop bit's vote. One held frame; a frame completing while it is unacknowledged is dropped with an overrun pulse.
module uart_rx_param #(
  parameter int FCLK      = 100000000,
  parameter int BAUD      = 115200,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic              rd_ack,
  output logic [DATA_W-1:0] rx_data,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              break_det,
  output logic              idle
);

  localparam int TICKS = FCLK / BAUD;
  localparam int MID   = (TICKS - 1) / 2;
  localparam int CW    = $clog2(TICKS);

  localparam logic [CW-1:0] C_RELOAD = CW'(TICKS - 1);
  localparam logic [CW-1:0] C_S1     = CW'(MID + 1);
  localparam logic [CW-1:0] C_S2     = CW'(MID);
  localparam logic [CW-1:0] C_DEC    = CW'(MID - 1);
  localparam logic [3:0]    C_LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0]    C_LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_BRK
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rx_meta;
  logic              r_rxs;
  logic [CW-1:0]     r_cnt;
  logic              r_s1;
  logic              r_s2;
  logic [3:0]        r_bidx;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_bit;
  logic              r_ferr_acc;

  logic [DATA_W-1:0] r_rx_data;
  logic              r_valid;
  logic              r_parity_err;
  logic              r_frame_err;
  logic              r_overrun;
  logic              r_break_det;

  logic w_maj;
  logic w_dec;
  logic w_end;
  logic w_cnt_load;
  logic w_shift_en;
  logic w_par_en;
  logic w_ferr_set;
  logic w_bidx_clr;
  logic w_bidx_inc;
  logic w_done;
  logic w_brk;
  logic w_brk_cond;
  logic w_perr;
  logic w_ferr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
    end
  end

  assign w_maj = (r_s1 & r_s2) | (r_s1 & r_rxs) | (r_s2 & r_rxs);
  assign w_dec = (r_cnt == C_DEC);
  assign w_end = (r_cnt == '0);

  // Break needs every data bit, the parity bit (if any) and the first stop bit low.
  assign w_brk_cond = !w_maj && (r_shift == '0) && ((PARITY == 0) || !r_par_bit);
  assign w_ferr     = r_ferr_acc | !w_maj;

  always_comb begin
    w_perr = 1'b0;
    if (PARITY == 1) begin
      w_perr = r_par_bit ^ (^r_shift);
    end else if (PARITY == 2) begin
      w_perr = r_par_bit ^ ~(^r_shift);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_ferr_set  = 1'b0;
    w_bidx_clr  = 1'b0;
    w_bidx_inc  = 1'b0;
    w_done      = 1'b0;
    w_brk       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_load = 1'b1;
        w_bidx_clr = 1'b1;
        if (!r_rxs) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_dec && w_maj) begin
          w_state_nxt = S_IDLE;
          w_cnt_load  = 1'b1;
        end else if (w_end) begin
          w_state_nxt = S_DATA;
          w_cnt_load  = 1'b1;
        end
      end
      S_DATA: begin
        w_shift_en = w_dec;
        if (w_end) begin
          w_cnt_load = 1'b1;
          if (r_bidx == C_LAST_DATA) begin
            w_bidx_clr  = 1'b1;
            w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            w_bidx_inc = 1'b1;
          end
        end
      end
      S_PAR: begin
        w_par_en = w_dec;
        if (w_end) begin
          w_cnt_load  = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_dec) begin
          w_ferr_set = !w_maj;
          if ((r_bidx == 4'd0) && w_brk_cond) begin
            w_brk       = 1'b1;
            w_state_nxt = S_BRK;
          end else if (r_bidx == C_LAST_STOP) begin
            w_done      = 1'b1;
            w_cnt_load  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_end) begin
          w_cnt_load = 1'b1;
          w_bidx_inc = 1'b1;
        end
      end
      S_BRK: begin
        w_cnt_load = 1'b1;
        if (r_rxs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_load  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= C_RELOAD;
      r_s1       <= 1'b1;
      r_s2       <= 1'b1;
      r_bidx     <= 4'd0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_ferr_acc <= 1'b0;
    end else begin
      if (w_cnt_load) begin
        r_cnt <= C_RELOAD;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (r_cnt == C_S1) begin
        r_s1 <= r_rxs;
      end
      if (r_cnt == C_S2) begin
        r_s2 <= r_rxs;
      end
      if (w_bidx_clr) begin
        r_bidx <= 4'd0;
      end else if (w_bidx_inc) begin
        r_bidx <= r_bidx + 4'd1;
      end
      if (w_shift_en) begin
        r_shift <= {w_maj, r_shift[DATA_W-1:1]};
      end
      if (w_par_en) begin
        r_par_bit <= w_maj;
      end
      if (r_state == S_IDLE) begin
        r_ferr_acc <= 1'b0;
      end else if (w_ferr_set) begin
        r_ferr_acc <= 1'b1;
      end
    end
  end

  // A completion coinciding with rd_ack replaces the held word rather than overrunning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data    <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_break_det  <= 1'b0;
    end else begin
      r_overrun   <= 1'b0;
      r_break_det <= w_brk;
      if (w_done) begin
        if (!r_valid || rd_ack) begin
          r_rx_data    <= r_shift;
          r_parity_err <= w_perr;
          r_frame_err  <= w_ferr;
          r_valid      <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (rd_ack && r_valid) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign valid      = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign break_det  = r_break_det;
  assign idle       = (r_state == S_IDLE);

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter FCLK, default 100000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate; TICKS = FCLK/BAUD clocks per bit, TICKS >= 8.
REQ-003 SHALL have parameter DATA_W, default 8, meaning data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked, 1 or 2.
REQ-006 SHALL have ports, in order: clk (in, 1, sole clock, rising edge); rst_n (in, 1, asynchronous active-low reset).
REQ-007 SHALL have port rx (in, 1), the asynchronous serial line, idle high.
REQ-008 SHALL have port rd_ack (in, 1), consumer acknowledge of the held frame.
REQ-009 SHALL have port rx_data (out, DATA_W), the received word, LSB first on the line.
REQ-010 SHALL have ports valid, parity_err, frame_err (out, 1 each), frame-held flags, all qualified by valid.
REQ-011 SHALL have ports overrun, break_det (out, 1 each), one-cycle pulses.
REQ-012 SHALL have port idle (out, 1), high only in state IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all logic uses the synchronized value rxs.
REQ-014 SHALL use a bit counter reloaded to TICKS-1 at each bit boundary and decremented to 0.
REQ-015 SHALL decide each bit by 2-of-3 majority of rxs at counter values M+1, M, M-1, M = (TICKS-1)/2.
REQ-016 SHALL have states IDLE, START, DATA, PAR, STOP, BRK.
REQ-017 IDLE -> START on rxs=0, counter loaded.
REQ-018 START: majority 1 -> IDLE, no output (false start); majority 0 -> DATA at counter 0.
REQ-019 DATA: shift DATA_W bits LSB first; after bit DATA_W-1 -> PAR if PARITY!=0, else STOP.
REQ-020 PAR: parity_err = received parity bit mismatches XOR of data (even) or XNOR (odd); PARITY=0 forces parity_err=0.
REQ-021 STOP: check STOP_BITS stop bits; any stop bit majority 0 sets frame_err; completion at the final stop bit's decision cycle, next state IDLE.
REQ-022 Completion latency: valid rises the cycle after the final stop bit's majority decision.
REQ-023 Break: data, parity (if present) and first stop bit all 0 -> pulse break_det, no valid, -> BRK; BRK -> IDLE on first rxs=1.
REQ-024 Non-break frame with frame_err SHALL still be delivered with frame_err=1.
REQ-025 valid SHALL hold, with rx_data and error flags stable, until a cycle with rd_ack=1; it clears the next cycle.
REQ-026 rd_ack with valid=0 SHALL have no effect.
REQ-027 Completion while valid=1 and rd_ack=0: keep old word and flags, drop the new frame, pulse overrun.
REQ-028 Completion in the same cycle as rd_ack=1: load the new word, valid stays 1, no overrun.
REQ-029 Receiver SHALL accept a new start bit one cycle after returning to IDLE, independent of valid.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, synchronizer flops to 1, counters to reload/0, rx_data=0, valid, parity_err, frame_err, overrun and break_det to 0, and idle to 1.
REQ-031 Reset mid-frame SHALL discard the partial frame; the first frame after release SHALL start at a fresh falling edge.

Verification (FCLK=16000000, BAUD=1000000, TICKS=16)
REQ-032 DATA_W=8, PARITY=0: send 0xA5, stop=1 -> valid=1, rx_data=0xA5, flags 0; rd_ack -> valid=0 next cycle.
REQ-033 PARITY=1: send 0x03 with parity bit 1 -> parity_err=1; with parity 0 -> parity_err=0.
REQ-034 1.5-tick-wide 0 glitch on idle rx -> no valid, state returns IDLE, no flags.
REQ-035 Send 0x11 then 0x22 with no rd_ack -> rx_data=0x11, one overrun pulse; ack coincident with second completion -> rx_data=0x22, no overrun.
REQ-036 rx low for 12 bit times -> one break_det pulse, valid stays 0; rx high, then 0x5A -> rx_data=0x5A.
REQ-037 rst_n pulsed low during data bit 4 -> outputs at reset values; next full frame 0x3C -> rx_data=0x3C.
